// File: rtl/adder_seq_pkg.sv
// Shared definitions for the nibble-serial adder sequencer.
package adder_seq_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } seq_state_t;

endpackage

// File: rtl/adder_4bit.sv
// 4-bit ripple-carry adder: the single datapath shared by every nibble of a run.
module adder_4bit
   import adder_seq_pkg::*;
(
   input  logic [NIBBLE_W-1:0] a,
   input  logic [NIBBLE_W-1:0] b,
   input  logic                cin,
   output logic [NIBBLE_W-1:0] sum,
   output logic                cout
);

   logic [NIBBLE_W:0] carry_s;

   // Chain full-adder cells, carry flowing from bit 0 upwards.
   always_comb begin
      carry_s    = '0;
      sum        = '0;
      carry_s[0] = cin;
      for (int i = 0; i < NIBBLE_W; i++) begin
         sum[i]       = a[i] ^ b[i] ^ carry_s[i];
         carry_s[i+1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
      end
   end

   assign cout = carry_s[NIBBLE_W];

endmodule

// File: rtl/adder_seq_ctrl.sv
// Wide adder built from one shared 4-bit adder, one nibble per cycle, LSB first,
// with valid/ready handshakes towards the producer and the consumer.
module adder_seq_ctrl
   import adder_seq_pkg::*;
#(
   parameter int NIBBLES = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          inValid,
   output logic                          outReady,
   input  logic [NIBBLE_W*NIBBLES-1:0]   inA,
   input  logic [NIBBLE_W*NIBBLES-1:0]   inB,
   input  logic                          inCarry,
   output logic                          outValid,
   input  logic                          inReady,
   output logic [NIBBLE_W*NIBBLES-1:0]   outSum,
   output logic                          outCarry,
   output logic                          outBusy
);

   localparam int WIDTH = NIBBLE_W * NIBBLES;
   localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

   seq_state_t           state_r;
   seq_state_t           state_s;
   logic [WIDTH-1:0]     op_a_r;
   logic [WIDTH-1:0]     op_b_r;
   logic [WIDTH-1:0]     sum_r;
   logic                 carry_r;
   logic [IDX_W-1:0]     idx_r;
   logic                 out_valid_r;
   logic                 out_ready_r;
   logic                 out_busy_r;

   logic [NIBBLE_W-1:0]  nib_a_s;
   logic [NIBBLE_W-1:0]  nib_b_s;
   logic [NIBBLE_W-1:0]  nib_sum_s;
   logic                 nib_cout_s;
   logic                 accept_s;
   logic                 last_s;

   // outReady is high exactly in IDLE, so accepting only needs the state and inValid.
   assign accept_s = (state_r == ST_IDLE) && inValid;
   assign last_s   = (idx_r == IDX_LAST);

   // Operand nibble currently being added.
   assign nib_a_s = op_a_r[NIBBLE_W*int'(idx_r) +: NIBBLE_W];
   assign nib_b_s = op_b_r[NIBBLE_W*int'(idx_r) +: NIBBLE_W];

   adder_4bit u_adder (
      .a    (nib_a_s),
      .b    (nib_b_s),
      .cin  (carry_r),
      .sum  (nib_sum_s),
      .cout (nib_cout_s)
   );

   // Next-state decode: accept in IDLE, step through nibbles in RUN, wait for the consumer in DONE.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (inValid) begin
               state_s = ST_RUN;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (last_s) begin
               state_s = ST_DONE;
            end else begin
               state_s = ST_RUN;
            end
         end
         ST_DONE: begin
            if (inReady) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_DONE;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // State, datapath registers and registered status flags; reset discards any run in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= ST_IDLE;
         op_a_r      <= '0;
         op_b_r      <= '0;
         sum_r       <= '0;
         carry_r     <= 1'b0;
         idx_r       <= '0;
         out_valid_r <= 1'b0;
         out_ready_r <= 1'b1;
         out_busy_r  <= 1'b0;
      end else begin
         state_r     <= state_s;
         out_valid_r <= (state_s == ST_DONE);
         out_ready_r <= (state_s == ST_IDLE);
         out_busy_r  <= (state_s != ST_IDLE);
         if (accept_s) begin
            // Result register is deliberately not cleared; each nibble is overwritten in turn.
            op_a_r  <= inA;
            op_b_r  <= inB;
            carry_r <= inCarry;
            idx_r   <= '0;
         end else if (state_r == ST_RUN) begin
            sum_r[NIBBLE_W*int'(idx_r) +: NIBBLE_W] <= nib_sum_s;
            carry_r <= nib_cout_s;
            idx_r   <= idx_r + IDX_ONE;
         end
      end
   end

   assign outValid = out_valid_r;
   assign outReady = out_ready_r;
   assign outBusy  = out_busy_r;
   assign outSum   = sum_r;
   assign outCarry = carry_r;

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Directed self-checking bench for adder_seq_ctrl (NIBBLES=4 and NIBBLES=1 builds).
module tb_adder_seq_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;

   // NIBBLES=4 instance
   logic        valid4, ready4, take4, cin4, ovalid4, cout4, busy4;
   logic [15:0] a4, b4, sum4;
   // NIBBLES=1 instance
   logic        valid1, ready1, take1, cin1, ovalid1, cout1, busy1;
   logic [3:0]  a1, b1, sum1;

   adder_seq_ctrl #(.NIBBLES(4)) u4 (
      .clk(clk), .reset(reset), .inValid(valid4), .outReady(ready4),
      .inA(a4), .inB(b4), .inCarry(cin4), .outValid(ovalid4), .inReady(take4),
      .outSum(sum4), .outCarry(cout4), .outBusy(busy4)
   );

   adder_seq_ctrl #(.NIBBLES(1)) u1 (
      .clk(clk), .reset(reset), .inValid(valid1), .outReady(ready1),
      .inA(a1), .inB(b1), .inCarry(cin1), .outValid(ovalid1), .inReady(take1),
      .outSum(sum1), .outCarry(cout1), .outBusy(busy1)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_valid4(input string tag);
      int lat = 0;
      while (ovalid4 !== 1'b1 && lat < 20) begin
         step();
         lat++;
      end
      check({tag, "_latency"}, lat, 4);
   endtask

   task automatic handshake4(input string tag);
      take4 = 1'b1;
      step();
      take4 = 1'b0;
      check({tag, "_valid_drop"}, {31'd0, ovalid4}, 32'd0);
      check({tag, "_ready_back"}, {31'd0, ready4}, 32'd1);
   endtask

   task automatic do_op4(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic [15:0] esum, input logic ecout);
      a4 = a; b4 = b; cin4 = cin; valid4 = 1'b1;
      step();
      valid4 = 1'b0;
      check({tag, "_busy"}, {31'd0, busy4}, 32'd1);
      check({tag, "_ready_low"}, {31'd0, ready4}, 32'd0);
      wait_valid4(tag);
      check({tag, "_sum"}, {16'd0, sum4}, {16'd0, esum});
      check({tag, "_cout"}, {31'd0, cout4}, {31'd0, ecout});
      handshake4(tag);
   endtask

   initial begin
      int t0;
      int t1;
      int lat;
      reset = 1'b1;
      valid4 = 1'b0; take4 = 1'b0; cin4 = 1'b0; a4 = 16'h0000; b4 = 16'h0000;
      valid1 = 1'b0; take1 = 1'b0; cin1 = 1'b0; a1 = 4'h0;     b1 = 4'h0;
      step();
      step();
      reset = 1'b0;

      // Reset state
      check("rst_valid", {31'd0, ovalid4}, 32'd0);
      check("rst_ready", {31'd0, ready4}, 32'd1);
      check("rst_busy",  {31'd0, busy4},  32'd0);
      check("rst_sum",   {16'd0, sum4},   32'd0);
      check("rst_cout",  {31'd0, cout4},  32'd0);
      check("rst1_ready", {31'd0, ready1}, 32'd1);

      // Zero operands
      do_op4("zero", 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);

      // Full carry ripple, carry register watched every RUN edge
      a4 = 16'hFFFF; b4 = 16'h0001; cin4 = 1'b0; valid4 = 1'b1;
      step();
      valid4 = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step();
         check($sformatf("ripple_carry%0d", k), {31'd0, u4.carry_r}, 32'd1);
      end
      check("ripple_valid", {31'd0, ovalid4}, 32'd1);
      check("ripple_sum",   {16'd0, sum4},   32'd0);
      check("ripple_cout",  {31'd0, cout4},  32'd1);
      handshake4("ripple");

      // Two ops back to back with the second request held while busy
      a4 = 16'h1234; b4 = 16'h4321; cin4 = 1'b1; valid4 = 1'b1;
      step();
      t0 = cyc;
      a4 = 16'h8000; b4 = 16'h8000; cin4 = 1'b0;
      wait_valid4("b2b_first");
      check("b2b_first_sum",  {16'd0, sum4},  32'h5556);
      check("b2b_first_cout", {31'd0, cout4}, 32'd0);
      take4 = 1'b1;
      step();
      take4 = 1'b0;
      step();
      t1 = cyc;
      valid4 = 1'b0;
      check("b2b_spacing", {31'd0, (t1 - t0) >= 6}, 32'd1);
      check("b2b_second_busy", {31'd0, busy4}, 32'd1);
      wait_valid4("b2b_second");
      check("b2b_second_sum",  {16'd0, sum4},  32'h0000);
      check("b2b_second_cout", {31'd0, cout4}, 32'd1);
      handshake4("b2b_second");

      // Backpressure in DONE with new operands waiting
      a4 = 16'hABCD; b4 = 16'h1111; cin4 = 1'b0; valid4 = 1'b1;
      step();
      a4 = 16'h0001; b4 = 16'h0002; cin4 = 1'b0;
      wait_valid4("bp");
      for (int k = 0; k < 5; k++) begin
         check($sformatf("bp_sum%0d", k),   {16'd0, sum4},   32'hBCDE);
         check($sformatf("bp_cout%0d", k),  {31'd0, cout4},  32'd0);
         check($sformatf("bp_ready%0d", k), {31'd0, ready4}, 32'd0);
         check($sformatf("bp_valid%0d", k), {31'd0, ovalid4}, 32'd1);
         step();
      end
      take4 = 1'b1;
      step();
      take4 = 1'b0;
      check("bp_release_ready", {31'd0, ready4}, 32'd1);
      check("bp_release_valid", {31'd0, ovalid4}, 32'd0);
      step();
      valid4 = 1'b0;
      check("bp_new_busy", {31'd0, busy4}, 32'd1);
      wait_valid4("bp_new");
      check("bp_new_sum",  {16'd0, sum4},  32'h0003);
      check("bp_new_cout", {31'd0, cout4}, 32'd0);
      handshake4("bp_new");

      // Reset on the second RUN cycle
      a4 = 16'hFFFF; b4 = 16'h0001; cin4 = 1'b0; valid4 = 1'b1;
      step();
      valid4 = 1'b0;
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("mid_rst_valid", {31'd0, ovalid4}, 32'd0);
      check("mid_rst_ready", {31'd0, ready4},  32'd1);
      check("mid_rst_busy",  {31'd0, busy4},   32'd0);
      check("mid_rst_sum",   {16'd0, sum4},    32'd0);
      check("mid_rst_cout",  {31'd0, cout4},   32'd0);
      for (int k = 0; k < 5; k++) begin
         step();
         check($sformatf("mid_rst_quiet%0d", k), {31'd0, ovalid4}, 32'd0);
      end
      do_op4("post_rst", 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0);

      // Single-nibble build
      a1 = 4'hF; b1 = 4'hF; cin1 = 1'b1; valid1 = 1'b1;
      step();
      valid1 = 1'b0;
      lat = 0;
      while (ovalid1 !== 1'b1 && lat < 20) begin
         step();
         lat++;
      end
      check("n1_latency", lat, 1);
      check("n1_sum",  {28'd0, sum1},  32'hF);
      check("n1_cout", {31'd0, cout1}, 32'd1);
      take1 = 1'b1;
      step();
      take1 = 1'b0;
      check("n1_ready_back", {31'd0, ready1}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/adder_seq_ctrl.md
Name: adder_seq_ctrl

Overview:
Multi-cycle sequencer that performs wide additions on one shared 4-bit ripple-carry adder (adder_4bit). It processes one nibble per cycle, LSB nibble first, and chains the carry through a register. A valid/ready handshake is used on both sides. It sits between an operand producer and a result consumer and trades latency for adder area.

Parameters:
NIBBLES, 4, number of 4-bit nibbles per operand; must be >= 1; operand width WIDTH = 4*NIBBLES (localparam).

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous active-high reset
inValid  input  1  producer has operands
outReady  output  1  block can accept operands (high only in IDLE)
inA  input  WIDTH  operand A
inB  input  WIDTH  operand B
inCarry  input  1  initial carry-in
outValid  output  1  result available (high only in DONE)
inReady  input  1  consumer takes result
outSum  output  WIDTH  sum A+B+inCarry mod 2^WIDTH
outCarry  output  1  final carry-out
outBusy  output  1  high in RUN or DONE

Behaviour:
- One clock, clk. reset is synchronous, active-high, and sampled on the rising edge of clk.
- Reset values: state=IDLE, outValid=0, outReady=1, outBusy=0, outSum=0, outCarry=0, nibble index=0, carry register=0.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - outReady=1.
  - On an edge with inValid&&outReady: latch inA, inB into operand registers, load inCarry into the carry register, clear idx, go to RUN.
  - inA, inB and inCarry are sampled only on this accept edge.
- RUN:
  - outReady=0.
  - Each cycle, the adder receives A[4*idx+:4], B[4*idx+:4] and the carry register.
  - On the edge: the result nibble at idx takes the adder sum, the carry register takes the adder carry, and idx increments.
  - When idx==NIBBLES-1 on that edge, go to DONE.
- DONE:
  - outValid=1. outSum is the result register; outCarry is the carry register.
  - On an edge with inReady: go to IDLE.
  - Otherwise, hold outSum and outCarry stable for as long as inReady stays low.
- Latency: outValid rises exactly NIBBLES cycles after the accepting edge.
  - Minimum initiation interval is NIBBLES+2 cycles: RUN, then a DONE handshake cycle, then one IDLE accept cycle. There is no back-to-back bypass.
- inValid while busy: ignored. No internal state changes, and the producer must hold its request.
- outSum and outCarry keep their last result after returning to IDLE, until overwritten by the next run. The result register is not cleared at accept; nibbles are overwritten in order.
- NIBBLES=1: a single RUN cycle, then DONE.
- Reset in any state (including mid-RUN or DONE with inReady low): the operation is discarded and all registers return to their reset values on that edge.
  - The next cycle is IDLE with outReady=1. A pending result is never presented.
- reset has priority over the handshakes on the same edge.
- Arithmetic: unsigned, modulo 2^WIDTH, with the carry-out in outCarry. There are no overflow or sign flags.

Decomposition:
- Package adder_seq_pkg:
  - NIBBLE_W=4.
  - typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} seq_state_t.
- Sub-module: one instance of adder_4bit as the shared nibble datapath. The controller, the operand/result registers and the idx counter ($clog2(NIBBLES) bits, minimum 1) live in adder_seq_ctrl.

Test Plan:
- NIBBLES=4, A=0x0000, B=0x0000, cin=0 -> outValid 4 cycles after accept, outSum=0x0000, outCarry=0.
- A=0xFFFF, B=0x0001, cin=0 -> outSum=0x0000, outCarry=1. Carry ripples through all nibbles; check the carry register each RUN cycle (1,1,1,1).
- A=0x1234, B=0x4321, cin=1 -> outSum=0x5556, outCarry=0.
  - Then A=0x8000, B=0x8000, cin=0 -> outSum=0x0000, outCarry=1.
  - Check the second accept occurs no earlier than 6 cycles after the first.
- Backpressure: hold inReady=0 for 5 cycles in DONE while inValid=1 with new operands.
  - Required: outSum and outCarry stable, outReady=0, new operands not accepted.
  - Raise inReady -> IDLE, then accept the new operands.
- Reset asserted on the 2nd RUN cycle of 0xFFFF+0x0001.
  - Required: next cycle outValid=0, outReady=1, outBusy=0, outSum=0.
  - A following 0x0F0F+0x00F1, cin=0 -> 0x1000, outCarry=0.
- NIBBLES=1 build: A=0xF, B=0xF, cin=1 -> outSum=0xF, outCarry=1, outValid 1 cycle after accept.
